// File: rtl/id_stage.sv
// Instruction decode stage for a 5-stage RV32I pipeline.
// Decodes the IF/ID instruction into the ID/EX register with one cycle of
// latency, hosts the 32x32 register file, and detects load-use hazards.
// A load-use hazard inserts one bubble and replays the stalled instruction
// from an internal replay register on the following cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   if_id_pc/instr      instruction and PC held in the IF/ID register
//   flush               redirect from EX, kills the instruction in decode
//   wb_we/rd/data       register-file write port from WB
//   hazard_stall        combinational load-use stall towards IF
//   id_ex_*             registered decode results
//   illegal_instr       one-cycle pulse for an unsupported opcode
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_pc,
  input  logic [31:0] if_id_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        hazard_stall,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_op,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_branch,
  output logic        id_ex_jump,
  output logic        id_ex_alu_src,
  output logic        id_ex_pc_src,
  output logic        illegal_instr
);

  typedef enum logic {NORMAL, REPLAY} state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        reg_write, mem_read, mem_write, branch, jump, alu_src, pc_src;
  } idex_t;

  state_t      state_q, state_d;
  logic [31:0] replay_instr_q, replay_instr_d;
  logic [31:0] replay_pc_q, replay_pc_d;
  idex_t       idex_q, idex_d;
  logic        illegal_q, illegal_d;
  logic [31:0] regs_q [32];

  logic [31:0] cur_instr, cur_pc;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal, rs1_used, rs2_used, has_rd;
  idex_t       dec, bubble;

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  assign cur_instr = (state_q == REPLAY) ? replay_instr_q : if_id_instr;
  assign cur_pc    = (state_q == REPLAY) ? replay_pc_q    : if_id_pc;

  assign imm_i = {{20{cur_instr[31]}}, cur_instr[31:20]};
  assign imm_s = {{20{cur_instr[31]}}, cur_instr[31:25], cur_instr[11:7]};
  assign imm_b = {{19{cur_instr[31]}}, cur_instr[31], cur_instr[7],
                  cur_instr[30:25], cur_instr[11:8], 1'b0};
  assign imm_u = {cur_instr[31:12], 12'h000};
  assign imm_j = {{11{cur_instr[31]}}, cur_instr[31], cur_instr[19:12],
                  cur_instr[20], cur_instr[30:21], 1'b0};

  // Unused register indices are zeroed so they can never match a load's rd
  // in the hazard check or a forwarding comparison downstream.
  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    has_rd   = 1'b0;
    dec.pc     = cur_pc;
    dec.funct3 = cur_instr[14:12];
    dec.alu_op = ALU_ADD;
    case (cur_instr[6:0])
      OPC_LUI:    begin has_rd = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_PASSB; dec.imm = imm_u; end
      OPC_AUIPC:  begin has_rd = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1; dec.imm = imm_u; end
      OPC_JAL:    begin has_rd = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1; dec.jump = 1'b1; dec.imm = imm_j; end
      OPC_JALR:   begin has_rd = 1'b1; rs1_used = 1'b1; dec.alu_src = 1'b1; dec.jump = 1'b1; dec.imm = imm_i; end
      OPC_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; dec.branch = 1'b1; dec.imm = imm_b; end
      OPC_LOAD:   begin has_rd = 1'b1; rs1_used = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.imm = imm_i; end
      OPC_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.imm = imm_s; end
      OPC_OPIMM:  begin
        has_rd = 1'b1; rs1_used = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i;
        dec.alu_op = alu_fn(cur_instr[14:12], cur_instr[30] && (cur_instr[14:12] == 3'b101));
      end
      OPC_OP:     begin
        has_rd = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.alu_op = alu_fn(cur_instr[14:12], cur_instr[30]);
      end
      default:    legal = 1'b0;
    endcase
    dec.rs1       = rs1_used ? cur_instr[19:15] : '0;
    dec.rs2       = rs2_used ? cur_instr[24:20] : '0;
    dec.rd        = has_rd   ? cur_instr[11:7]  : '0;
    dec.reg_write = has_rd && (dec.rd != '0);
    // Same-cycle WB write is bypassed so the register file needs no read-after-write ordering.
    if (dec.rs1 != '0) dec.rs1_data = (wb_we && wb_rd == dec.rs1) ? wb_data : regs_q[dec.rs1];
    if (dec.rs2 != '0) dec.rs2_data = (wb_we && wb_rd == dec.rs2) ? wb_data : regs_q[dec.rs2];
  end

  // While replaying, ID/EX holds a bubble (mem_read=0), so no second stall can occur.
  always_comb begin
    hazard_stall = idex_q.mem_read && (idex_q.rd != '0) && !flush &&
                   ((dec.rs1 == idex_q.rd) || (dec.rs2 == idex_q.rd));
  end

  always_comb begin
    state_d        = state_q;
    replay_instr_d = replay_instr_q;
    replay_pc_d    = replay_pc_q;
    bubble         = '0;
    bubble.pc      = idex_q.pc;
    idex_d         = dec;
    illegal_d      = 1'b0;
    if (flush) begin
      idex_d         = bubble;
      state_d        = NORMAL;
      replay_instr_d = NOP_INSTR;
      replay_pc_d    = '0;
    end else if (hazard_stall) begin
      idex_d         = bubble;
      state_d        = REPLAY;
      replay_instr_d = cur_instr;
      replay_pc_d    = cur_pc;
    end else begin
      state_d = NORMAL;
      if (!legal) begin
        idex_d    = bubble;
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= NORMAL;
      replay_instr_q <= '0;
      replay_pc_q    <= '0;
      idex_q         <= '0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      replay_instr_q <= replay_instr_d;
      replay_pc_q    <= replay_pc_d;
      idex_q         <= idex_d;
      illegal_q      <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign id_ex_pc        = idex_q.pc;
  assign id_ex_imm       = idex_q.imm;
  assign id_ex_rs1_data  = idex_q.rs1_data;
  assign id_ex_rs2_data  = idex_q.rs2_data;
  assign id_ex_rs1       = idex_q.rs1;
  assign id_ex_rs2       = idex_q.rs2;
  assign id_ex_rd        = idex_q.rd;
  assign id_ex_alu_op    = idex_q.alu_op;
  assign id_ex_funct3    = idex_q.funct3;
  assign id_ex_reg_write = idex_q.reg_write;
  assign id_ex_mem_read  = idex_q.mem_read;
  assign id_ex_mem_write = idex_q.mem_write;
  assign id_ex_branch    = idex_q.branch;
  assign id_ex_jump      = idex_q.jump;
  assign id_ex_alu_src   = idex_q.alu_src;
  assign id_ex_pc_src    = idex_q.pc_src;
  assign illegal_instr   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode fields, register file and bypass,
// load-use stall/replay, flush priority, illegal opcodes and reset.
module tb_id_stage;

  logic        clk, reset, flush, wb_we;
  logic [31:0] if_id_pc, if_id_instr, wb_data;
  logic [4:0]  wb_rd;
  logic        hazard_stall, illegal_instr;
  logic [31:0] id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]  id_ex_alu_op;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch;
  logic        id_ex_jump, id_ex_alu_src, id_ex_pc_src;
  logic [6:0]  ctrl;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  id_stage #(.NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .id_ex_pc(id_ex_pc), .id_ex_imm(id_ex_imm),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_funct3(id_ex_funct3),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch),
    .id_ex_jump(id_ex_jump), .id_ex_alu_src(id_ex_alu_src),
    .id_ex_pc_src(id_ex_pc_src), .illegal_instr(illegal_instr)
  );

  // {reg_write, mem_read, mem_write, branch, jump, alu_src, pc_src}
  assign ctrl = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
                 id_ex_jump, id_ex_alu_src, id_ex_pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    if_id_pc    = pc;
    if_id_instr = instr;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(32'h0000_0040, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step(); step();
    checks++; if (ctrl !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0); end
    checks++; if ({id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data} !== 128'h0) begin failures++; $display("FAIL reset_data got=%h %h exp=0", id_ex_pc, id_ex_imm); end
    checks++; if ({id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_alu_op, id_ex_funct3, illegal_instr} !== 23'h0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_alu_op, id_ex_funct3, illegal_instr}); end
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", hazard_stall); end
    reset = 1'b0;
    drive(32'h0000_0044, enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6));
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%b exp=0", hazard_stall); end
    step();
  endtask

  task automatic test_addi();
    drive(32'h0000_0100, 32'h00500093);
    step();
    checks++; if (id_ex_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=%h", id_ex_imm, 32'd5); end
    checks++; if (id_ex_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", id_ex_rd); end
    checks++; if (ctrl !== 7'b1000010) begin failures++; $display("FAIL addi_ctrl got=%b exp=1000010", ctrl); end
    checks++; if (id_ex_alu_op !== 4'd0 || id_ex_pc !== 32'h100) begin failures++; $display("FAIL addi_op_pc got=%0d/%h exp=0/100", id_ex_alu_op, id_ex_pc); end
    // ADDI x1,x0,-1024: instr[30]=1 must not turn ADDI into SUB
    drive(32'h0000_0104, enc_i(12'hC00, 5'd0, 3'b000, 5'd1, 7'b0010011));
    step();
    checks++; if (id_ex_alu_op !== 4'd0 || id_ex_imm !== 32'hFFFFFC00) begin failures++; $display("FAIL addi_neg got=%0d/%h exp=0/fffffc00", id_ex_alu_op, id_ex_imm); end
  endtask

  task automatic test_regfile();
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    drive(32'h0000_0110, enc_r(7'd0, 5'd2, 5'd2, 3'b000, 5'd3));
    step();
    checks++; if (id_ex_rs1_data !== 32'hDEADBEEF || id_ex_rs2_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass got=%h/%h exp=deadbeef", id_ex_rs1_data, id_ex_rs2_data); end
    checks++; if (ctrl !== 7'b1000000 || id_ex_rd !== 5'd3) begin failures++; $display("FAIL add_ctrl got=%b/%0d exp=1000000/3", ctrl, id_ex_rd); end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    drive(32'h0000_0114, enc_r(7'd0, 5'd0, 5'd2, 3'b000, 5'd4));
    step();
    checks++; if (id_ex_rs1_data !== 32'hDEADBEEF || id_ex_rs2_data !== 32'h0) begin failures++; $display("FAIL rf_read got=%h/%h exp=deadbeef/0", id_ex_rs1_data, id_ex_rs2_data); end
    wb_we = 1'b0;
    drive(32'h0000_0118, enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd5));
    step();
    checks++; if (id_ex_rs1_data !== 32'h0) begin failures++; $display("FAIL x0_write got=%h exp=0", id_ex_rs1_data); end
  endtask

  task automatic test_imm_formats();
    drive(32'h0000_0200, {20'hABCDE, 5'd7, 7'b0110111});
    step();
    checks++; if (id_ex_imm !== 32'hABCDE000 || id_ex_alu_op !== 4'd10 || ctrl !== 7'b1000010) begin failures++; $display("FAIL lui got=%h/%0d/%b exp=abcde000/10/1000010", id_ex_imm, id_ex_alu_op, ctrl); end
    drive(32'h0000_0204, {20'h12345, 5'd8, 7'b0010111});
    step();
    checks++; if (id_ex_imm !== 32'h12345000 || id_ex_alu_op !== 4'd0 || ctrl !== 7'b1000011) begin failures++; $display("FAIL auipc got=%h/%0d/%b exp=12345000/0/1000011", id_ex_imm, id_ex_alu_op, ctrl); end
    drive(32'h0000_0208, enc_j(21'h1FFFFC, 5'd1));
    step();
    checks++; if (id_ex_imm !== 32'hFFFFFFFC || ctrl !== 7'b1000111 || id_ex_rs1 !== 5'd0) begin failures++; $display("FAIL jal got=%h/%b/%0d exp=fffffffc/1000111/0", id_ex_imm, ctrl, id_ex_rs1); end
    drive(32'h0000_020C, enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111));
    step();
    checks++; if (ctrl !== 7'b0000110 || id_ex_rs1 !== 5'd1 || id_ex_rd !== 5'd0) begin failures++; $display("FAIL jalr_x0 got=%b/%0d/%0d exp=0000110/1/0", ctrl, id_ex_rs1, id_ex_rd); end
    drive(32'h0000_0210, enc_b(13'h1000, 5'd2, 5'd1, 3'b001));
    step();
    checks++; if (id_ex_imm !== 32'hFFFFF000 || ctrl !== 7'b0001000 || id_ex_funct3 !== 3'b001) begin failures++; $display("FAIL bne got=%h/%b/%0d exp=fffff000/0001000/1", id_ex_imm, ctrl, id_ex_funct3); end
    checks++; if (id_ex_rs1 !== 5'd1 || id_ex_rs2 !== 5'd2 || id_ex_rd !== 5'd0) begin failures++; $display("FAIL bne_regs got=%0d/%0d/%0d exp=1/2/0", id_ex_rs1, id_ex_rs2, id_ex_rd); end
    drive(32'h0000_0214, enc_b(13'd8, 5'd2, 5'd1, 3'b000));
    step();
    checks++; if (id_ex_imm !== 32'd8) begin failures++; $display("FAIL beq_imm got=%h exp=8", id_ex_imm); end
    drive(32'h0000_0218, enc_s(12'hFF4, 5'd2, 5'd1, 3'b010));
    step();
    checks++; if (id_ex_imm !== 32'hFFFFFFF4 || ctrl !== 7'b0010010 || id_ex_rs2 !== 5'd2) begin failures++; $display("FAIL sw got=%h/%b/%0d exp=fffffff4/0010010/2", id_ex_imm, ctrl, id_ex_rs2); end
  endtask

  task automatic test_alu_ops();
    drive(32'h0000_0300, enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd9, 7'b0010011));
    step();
    checks++; if (id_ex_alu_op !== 4'd7 || id_ex_imm !== 32'h403) begin failures++; $display("FAIL srai got=%0d/%h exp=7/403", id_ex_alu_op, id_ex_imm); end
    drive(32'h0000_0304, enc_i(12'hFFF, 5'd1, 3'b100, 5'd9, 7'b0010011));
    step();
    checks++; if (id_ex_alu_op !== 4'd5 || id_ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL xori got=%0d/%h exp=5/ffffffff", id_ex_alu_op, id_ex_imm); end
    drive(32'h0000_0308, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd10));
    step();
    checks++; if (id_ex_alu_op !== 4'd1) begin failures++; $display("FAIL sub got=%0d exp=1", id_ex_alu_op); end
    drive(32'h0000_030C, enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd10));
    step();
    checks++; if (id_ex_alu_op !== 4'd7) begin failures++; $display("FAIL sra got=%0d exp=7", id_ex_alu_op); end
    drive(32'h0000_0310, enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd10));
    step();
    checks++; if (id_ex_alu_op !== 4'd6) begin failures++; $display("FAIL srl got=%0d exp=6", id_ex_alu_op); end
    drive(32'h0000_0314, enc_r(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd10));
    step();
    checks++; if (id_ex_alu_op !== 4'd4) begin failures++; $display("FAIL sltu got=%0d exp=4", id_ex_alu_op); end
    drive(32'h0000_0318, enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd10));
    step();
    checks++; if (id_ex_alu_op !== 4'd9) begin failures++; $display("FAIL and got=%0d exp=9", id_ex_alu_op); end
  endtask

  task automatic test_load_use();
    drive(32'h0000_0400, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    checks++; if (id_ex_mem_read !== 1'b1 || id_ex_rd !== 5'd5) begin failures++; $display("FAIL lw got=%b/%0d exp=1/5", id_ex_mem_read, id_ex_rd); end
    drive(32'h0000_0404, enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6));
    #1;
    checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", hazard_stall); end
    step();
    checks++; if (ctrl !== 7'b0 || id_ex_rd !== 5'd0 || id_ex_rs1 !== 5'd0 || id_ex_imm !== 32'h0) begin failures++; $display("FAIL lu_bubble got=%b/%0d/%0d/%h exp=0", ctrl, id_ex_rd, id_ex_rs1, id_ex_imm); end
    checks++; if (id_ex_pc !== 32'h400 || hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_bubble_pc got=%h/%b exp=400/0", id_ex_pc, hazard_stall); end
    // IF inputs must be ignored during the replay cycle
    drive(32'h0000_0999, 32'h00A00513);
    step();
    checks++; if (id_ex_rd !== 5'd6 || id_ex_rs1 !== 5'd5 || id_ex_pc !== 32'h404 || ctrl !== 7'b1000000) begin failures++; $display("FAIL lu_replay got=%0d/%0d/%h/%b exp=6/5/404/1000000", id_ex_rd, id_ex_rs1, id_ex_pc, ctrl); end
    // store data dependency through rs2
    drive(32'h0000_0410, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    drive(32'h0000_0414, enc_s(12'd4, 5'd5, 5'd2, 3'b010));
    #1;
    checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL sw_rs2_stall got=%b exp=1", hazard_stall); end
    step(); step();
    checks++; if (id_ex_mem_write !== 1'b1 || id_ex_rs2 !== 5'd5 || id_ex_pc !== 32'h414) begin failures++; $display("FAIL sw_replay got=%b/%0d/%h exp=1/5/414", id_ex_mem_write, id_ex_rs2, id_ex_pc); end
    // LUI whose immediate bits alias rs1=x5 must not stall
    drive(32'h0000_0420, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    drive(32'h0000_0424, {20'h00028, 5'd7, 7'b0110111});
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lui_no_stall got=%b exp=0", hazard_stall); end
    step();
  endtask

  task automatic test_flush();
    drive(32'h0000_0500, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    drive(32'h0000_0504, enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6));
    flush = 1'b1;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", hazard_stall); end
    step();
    checks++; if (ctrl !== 7'b0 || id_ex_rd !== 5'd0 || id_ex_pc !== 32'h500) begin failures++; $display("FAIL flush_bubble got=%b/%0d/%h exp=0/0/500", ctrl, id_ex_rd, id_ex_pc); end
    flush = 1'b0;
    drive(32'h0000_0508, 32'h00500093);
    step();
    checks++; if (id_ex_rd !== 5'd1 || id_ex_pc !== 32'h508) begin failures++; $display("FAIL flush_next got=%0d/%h exp=1/508", id_ex_rd, id_ex_pc); end
    // flush arriving in the replay cycle discards the replay
    drive(32'h0000_0510, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    drive(32'h0000_0514, enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6));
    step();
    flush = 1'b1;
    drive(32'h0000_0600, 32'h00500093);
    step();
    checks++; if (ctrl !== 7'b0 || id_ex_rd !== 5'd0 || id_ex_pc !== 32'h510) begin failures++; $display("FAIL flush_replay got=%b/%0d/%h exp=0/0/510", ctrl, id_ex_rd, id_ex_pc); end
    flush = 1'b0;
    drive(32'h0000_0604, 32'h00500093);
    step();
    checks++; if (id_ex_rd !== 5'd1 || id_ex_pc !== 32'h604) begin failures++; $display("FAIL flush_replay_next got=%0d/%h exp=1/604", id_ex_rd, id_ex_pc); end
  endtask

  task automatic test_illegal();
    drive(32'h0000_0700, 32'hFFFFFFFF);
    step();
    checks++; if (illegal_instr !== 1'b1 || ctrl !== 7'b0 || id_ex_rd !== 5'd0 || id_ex_imm !== 32'h0) begin failures++; $display("FAIL illegal got=%b/%b/%0d/%h exp=1/0/0/0", illegal_instr, ctrl, id_ex_rd, id_ex_imm); end
    checks++; if (id_ex_pc !== 32'h604) begin failures++; $display("FAIL illegal_pc got=%h exp=604", id_ex_pc); end
    drive(32'h0000_0704, NOP);
    step();
    checks++; if (illegal_instr !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%b exp=0", illegal_instr); end
    checks++; if (ctrl !== 7'b0000010 || id_ex_rd !== 5'd0 || id_ex_imm !== 32'h0 || id_ex_alu_op !== 4'd0) begin failures++; $display("FAIL nop got=%b/%0d/%h/%0d exp=0000010/0/0/0", ctrl, id_ex_rd, id_ex_imm, id_ex_alu_op); end
  endtask

  task automatic test_reset_in_replay();
    drive(32'h0000_0800, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    step();
    drive(32'h0000_0804, enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6));
    step();
    reset = 1'b1;
    #1;
    checks++; if (id_ex_pc !== 32'h0 || ctrl !== 7'b0 || illegal_instr !== 1'b0 || hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_async got=%h/%b/%b/%b exp=0", id_ex_pc, ctrl, illegal_instr, hazard_stall); end
    step();
    reset = 1'b0;
    drive(32'h0000_0900, enc_r(7'd0, 5'd2, 5'd2, 3'b000, 5'd3));
    step();
    checks++; if (id_ex_rd !== 5'd3 || id_ex_pc !== 32'h900 || id_ex_rs1 !== 5'd2) begin failures++; $display("FAIL reset_resume got=%0d/%h/%0d exp=3/900/2", id_ex_rd, id_ex_pc, id_ex_rs1); end
    checks++; if (id_ex_rs1_data !== 32'h0) begin failures++; $display("FAIL reset_rf got=%h exp=0", id_ex_rs1_data); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_regfile();
    test_imm_formats();
    test_alu_ops();
    test_load_use();
    test_flush();
    test_illegal();
    test_reset_in_replay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, bubble/idle instruction value.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 if_id_pc  in  32  PC of the instruction in the IF/ID register.
REQ-005 if_id_instr  in  32  instruction in the IF/ID register; NOP_INSTR when IF is bubbling.
REQ-006 flush  in  1  branch/jump redirect from EX; kills the instruction being decoded.
REQ-007 wb_we, wb_rd, wb_data  in  1/5/32  register-file write port from WB.
REQ-008 hazard_stall  out  1  combinational load-use stall, fed to the IF combined_stall.
REQ-009 id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data  out  32 each  registered ID/EX fields.
REQ-010 id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered register indices.
REQ-011 id_ex_alu_op  out  4  registered ALU op; id_ex_funct3  out  3  registered funct3.
REQ-012 id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_pc_src  out  1 each  registered controls (pc_src=1 selects PC as ALU A).
REQ-013 illegal_instr  out  1  registered one-cycle pulse for an unsupported opcode.

Function
REQ-014 Decode latency SHALL be one cycle: fields decoded from the current instruction appear on id_ex_* after the next rising edge.
REQ-015 Supported opcodes SHALL be LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
REQ-016 Immediates SHALL be sign-extended I/S/B/U/J formats; U = instr[31:12]<<12; B/J bit 0 = 0.
REQ-017 ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; OP uses funct7[5] for SUB/SRA, OP-IMM uses it only for SRAI; LUI=PASSB; LOAD/STORE/JAL/JALR/AUIPC/BRANCH=ADD.
REQ-018 Controls: reg_write for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd!=0; alu_src for all but OP/BRANCH; pc_src for AUIPC/JAL; jump for JAL/JALR.
REQ-019 Register file: 32x32, x0 reads 0, writes to x0 ignored, written at rising edge when wb_we=1.
REQ-020 Write-read bypass: when wb_we=1 and wb_rd!=0 equals a source index in the same cycle, the read SHALL return wb_data.
REQ-021 rs1 "used" by all supported opcodes except LUI/AUIPC/JAL; rs2 "used" by BRANCH/STORE/OP.
REQ-022 hazard_stall SHALL be 1 when id_ex_mem_read=1, id_ex_rd!=0, flush=0, and id_ex_rd matches a used source of the current instruction.
REQ-023 Replay FSM states NORMAL, REPLAY; current instruction is if_id_instr/if_id_pc in NORMAL, replay_instr/replay_pc in REPLAY.
REQ-024 NORMAL->REPLAY on hazard_stall: current instruction/PC captured into replay registers, bubble written to ID/EX.
REQ-025 REPLAY->NORMAL after exactly one cycle: replayed instruction decoded into ID/EX; if_id inputs ignored that cycle.
REQ-026 Bubble: all control bits 0, rd/rs1/rs2 0, imm/data 0, alu_op ADD, funct3 0, pc retained.
REQ-027 flush SHALL have priority over stall and replay: bubble into ID/EX, replay cleared, state NORMAL.
REQ-028 Unsupported opcode SHALL produce a bubble and illegal_instr=1 for one cycle; NOP_INSTR decodes as ADDI x0,x0,0 with reg_write=0.

Reset
REQ-029 On reset all id_ex_* outputs, illegal_instr, replay registers and all 32 registers SHALL be 0 and state NORMAL; assertion mid-replay SHALL discard the replay.
REQ-030 hazard_stall SHALL be 0 while reset is asserted and in the first cycle after release.

Verification
REQ-031 ADDI x1,x0,5 (32'h00500093) -> next cycle id_ex_imm=5, rd=1, alu_src=1, reg_write=1, alu_op=0.
REQ-032 wb_we=1, wb_rd=2, wb_data=32'hDEADBEEF with ADD x3,x2,x2 in ID -> id_ex_rs1_data=id_ex_rs2_data=32'hDEADBEEF.
REQ-033 LW x5,0(x1) followed by ADD x6,x5,x0 -> hazard_stall=1 one cycle, one bubble in ID/EX, then ADD issues with rs1=5.
REQ-034 flush=1 during load-use stall -> bubble in ID/EX, state NORMAL, hazard_stall=0.
REQ-035 Opcode 7'b1111111 -> illegal_instr=1 one cycle, all controls 0.
REQ-036 Reset asserted while in REPLAY -> all outputs 0 immediately; after release, next valid instruction decodes normally.
